// File: rtl/pipeexe_md.sv
// Execute stage: single-cycle ALU with jal link path, plus an iterative
// radix-2 multiply/divide unit owning the architectural HI/LO registers.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no MD op in flight; an MD op in EXE asserts estall
// S_RUN  | one shift-add / restoring-divide step per cycle, estall high
// S_DONE | result in HI/LO, MD instruction leaves EXE, emd_op ignored
module pipeexe_md #(
   parameter int          WIDTH    = 32,
   parameter int          SAW      = $clog2(WIDTH),
   parameter logic [4:0]  LINK_REG = 5'd31,
   parameter int          LINK_OFS = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       ealuc,
   input  logic             ealuimm,
   input  logic             eshift,
   input  logic             ejal,
   input  logic [WIDTH-1:0] ea,
   input  logic [WIDTH-1:0] eb,
   input  logic [WIDTH-1:0] eimm,
   input  logic [WIDTH-1:0] epc4,
   input  logic [4:0]       ern0,
   input  logic [3:0]       emd_op,
   output logic [WIDTH-1:0] ealu,
   output logic [4:0]       ern,
   output logic             estall,
   output logic             ebusy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] LP_LINK_ADJ = WIDTH'(LINK_OFS - 4);

   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_count;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_m;
   logic               r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [WIDTH-1:0]   w_sa;
   logic [WIDTH-1:0]   w_alua;
   logic [WIDTH-1:0]   w_alub;
   logic [SAW-1:0]     w_shamt;
   logic [WIDTH-1:0]   w_alu;

   logic               w_md_op;
   logic               w_is_div;
   logic               w_signed;
   logic               w_start;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;

   logic [WIDTH:0]     w_msum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH:0]     w_rsh;
   logic [WIDTH:0]     w_diff;
   logic               w_ge;
   logic [WIDTH-1:0]   w_div_rem;
   logic [WIDTH-1:0]   w_div_q;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   // ALU operand selection; shift amount comes from the shamt field of eimm
   always_comb begin
      w_sa    = {{(WIDTH-SAW){1'b0}}, eimm[SAW+5:6]};
      w_alua  = eshift ? w_sa : ea;
      w_alub  = ealuimm ? eimm : eb;
      w_shamt = w_alua[SAW-1:0];
   end

   // ALU function decode
   always_comb begin
      w_alu = '0;
      casez (ealuc)
         4'b?000: w_alu = w_alua + w_alub;
         4'b?100: w_alu = w_alua - w_alub;
         4'b?001: w_alu = w_alua & w_alub;
         4'b?101: w_alu = w_alua | w_alub;
         4'b?010: w_alu = w_alua ^ w_alub;
         4'b?110: w_alu = w_alub << (WIDTH/2);
         4'b0011: w_alu = w_alub << w_shamt;
         4'b0111: w_alu = w_alub >> w_shamt;
         4'b1111: w_alu = $signed(w_alub) >>> w_shamt;
         default: w_alu = '0;
      endcase
   end

   // Stage result and destination register
   always_comb begin
      if (ejal)
         ealu = epc4 + LP_LINK_ADJ;
      else if (emd_op == MD_MFHI)
         ealu = r_hi;
      else if (emd_op == MD_MFLO)
         ealu = r_lo;
      else
         ealu = w_alu;
      ern = ejal ? LINK_REG : ern0;
   end

   // MD op decode and operand magnitudes for the start edge
   always_comb begin
      w_md_op  = (emd_op == MD_MULT) || (emd_op == MD_MULTU) ||
                 (emd_op == MD_DIV)  || (emd_op == MD_DIVU);
      w_is_div = (emd_op == MD_DIV) || (emd_op == MD_DIVU);
      w_signed = (emd_op == MD_MULT) || (emd_op == MD_DIV);
      w_start  = (r_state == S_IDLE) && w_md_op;
      w_a_neg  = w_signed & ea[WIDTH-1];
      w_b_neg  = w_signed & eb[WIDTH-1];
      w_a_mag  = w_a_neg ? -ea : ea;
      w_b_mag  = w_b_neg ? -eb : eb;
      estall   = w_start || (r_state == S_RUN);
      ebusy    = (r_state != S_IDLE);
   end

   // One iteration step: shift-add multiply or restoring divide, plus sign fix
   always_comb begin
      w_msum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
      w_mul_next = {w_msum, r_q[WIDTH-1:1]};
      w_prod_fix = r_neg_q ? -w_mul_next : w_mul_next;
      w_rsh      = {r_acc, r_q[WIDTH-1]};
      w_diff     = w_rsh - {1'b0, r_m};
      w_ge       = ~w_diff[WIDTH];
      w_div_rem  = w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
      w_div_q    = {r_q[WIDTH-2:0], w_ge};
      w_quo_fix  = r_neg_q ? -w_div_q : w_div_q;
      w_rem_fix  = r_neg_r ? -w_div_rem : w_div_rem;
   end

   // MD sequencer, iteration registers and HI/LO
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_m     <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  if (w_is_div && (eb == '0)) begin
                     r_lo    <= '1;
                     r_hi    <= ea;
                     r_state <= S_DONE;
                  end else begin
                     r_acc   <= '0;
                     r_q     <= w_a_mag;
                     r_m     <= w_b_mag;
                     r_div   <= w_is_div;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                     r_count <= CW'(WIDTH);
                     r_state <= S_RUN;
                  end
               end else if (emd_op == MD_MTHI) begin
                  r_hi <= ea;
               end else if (emd_op == MD_MTLO) begin
                  r_lo <= ea;
               end
            end
            S_RUN: begin
               if (r_div) begin
                  r_acc <= w_div_rem;
                  r_q   <= w_div_q;
               end else begin
                  r_acc <= w_mul_next[2*WIDTH-1:WIDTH];
                  r_q   <= w_mul_next[WIDTH-1:0];
               end
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) begin
                  if (r_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quo_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeexe_md.sv
// Bench for pipeexe_md: WIDTH=32 instance for the main checks, WIDTH=16
// instance for the narrow-datapath cases.
module tb_pipeexe_md;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                          OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MFHI = 4'd5,
                          OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

   // 32-bit instance
   logic        reset, ealuimm, eshift, ejal;
   logic [3:0]  ealuc, emd_op;
   logic [31:0] ea, eb, eimm, epc4, ealu;
   logic [4:0]  ern0, ern;
   logic        estall, ebusy;

   pipeexe_md #(.WIDTH(32)) dut (
      .clock(clk), .reset(reset), .ealuc(ealuc), .ealuimm(ealuimm),
      .eshift(eshift), .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm),
      .epc4(epc4), .ern0(ern0), .emd_op(emd_op), .ealu(ealu), .ern(ern),
      .estall(estall), .ebusy(ebusy)
   );

   // 16-bit instance
   logic        h_reset, h_ealuimm, h_eshift, h_ejal;
   logic [3:0]  h_ealuc, h_emd_op;
   logic [15:0] h_ea, h_eb, h_eimm, h_epc4, h_ealu;
   logic [4:0]  h_ern0, h_ern;
   logic        h_estall, h_ebusy;

   pipeexe_md #(.WIDTH(16)) dut16 (
      .clock(clk), .reset(h_reset), .ealuc(h_ealuc), .ealuimm(h_ealuimm),
      .eshift(h_eshift), .ejal(h_ejal), .ea(h_ea), .eb(h_eb), .eimm(h_eimm),
      .epc4(h_epc4), .ern0(h_ern0), .emd_op(h_emd_op), .ealu(h_ealu),
      .ern(h_ern), .estall(h_estall), .ebusy(h_ebusy)
   );

   int checks = 0;
   int errors = 0;
   bit done16 = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference ALU from the instruction semantics
   function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = a[4:0];
      case (c)
         4'd0, 4'd8:  return a + b;
         4'd4, 4'd12: return a - b;
         4'd1, 4'd9:  return a & b;
         4'd5, 4'd13: return a | b;
         4'd2, 4'd10: return a ^ b;
         4'd6, 4'd14: return b * 32'h0001_0000;
         4'd3:        return b * (32'd1 << sh);
         4'd7:        return b / (32'd1 << sh);
         4'd15:       return $signed(b) >>> sh;
         default:     return 32'd0;
      endcase
   endfunction

   // Reference HI/LO from 64-bit arithmetic
   task automatic md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         OP_MULT:  begin q = sa * sb; p = q; hi = p[63:32]; lo = p[31:0]; end
         OP_MULTU: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
         OP_DIV:   begin
            if (b == 32'd0) begin lo = '1; hi = a; end
            else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
         end
         OP_DIVU:  begin
            if (b == 32'd0) begin lo = '1; hi = a; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endtask

   // Issue one MD op (held while stalled), then read it back with mfhi/mflo
   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int stalls, exp_st;
      bit done;
      exp_st = ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) ? 1 : 33;
      ejal = 1'b0; emd_op = op; ea = a; eb = b;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (estall) stalls++;
         else done = 1'b1;
         if (!done) next_cycle();
      end
      chk({tag, " stall cycles"}, 64'(stalls), 64'(exp_st));
      chk({tag, " busy in DONE"}, 64'(ebusy), 64'd1);
      next_cycle();
      emd_op = OP_MFHI;
      @(negedge clk);
      chk({tag, " HI"}, 64'(ealu), 64'(exp_hi));
      chk({tag, " idle after"}, {62'd0, ebusy, estall}, 64'd0);
      next_cycle();
      emd_op = OP_MFLO;
      @(negedge clk);
      chk({tag, " LO"}, 64'(ealu), 64'(exp_lo));
      next_cycle();
      emd_op = OP_NONE;
   endtask

   typedef struct {
      logic [3:0]  aluc;
      logic        aluimm, shift, jal;
      logic [31:0] a, b, imm, pc4;
      logic [4:0]  rn0;
      logic [31:0] exp_alu;
      logic [4:0]  exp_rn;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] rh, rl, ra, rb, sa_a, exp;
      logic [3:0]  rop, codes[9];
      codes = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd15};

      vecs[0]  = '{4'd0,  1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'h1004, 5'd5, 32'h1008, 5'd31};
      vecs[1]  = '{4'd0,  1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'h1004, 5'd5, 32'd7, 5'd5};
      vecs[2]  = '{4'd4,  1'b0, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0, 32'd0, 5'd9, 32'd7, 5'd9};
      vecs[3]  = '{4'd1,  1'b0, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd1, 32'hF000, 5'd1};
      vecs[4]  = '{4'd5,  1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0F00, 32'd0, 32'd0, 5'd2, 32'hFFF0, 5'd2};
      vecs[5]  = '{4'd2,  1'b0, 1'b0, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0, 5'd3, 32'hF0, 5'd3};
      vecs[6]  = '{4'd6,  1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1234, 32'd0, 5'd4, 32'h1234_0000, 5'd4};
      vecs[7]  = '{4'd3,  1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 32'h100, 32'd0, 5'd6, 32'h10, 5'd6};
      vecs[8]  = '{4'd7,  1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'h7C0, 32'd0, 5'd7, 32'd1, 5'd7};
      vecs[9]  = '{4'd15, 1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'h100, 32'd0, 5'd8, 32'hF800_0000, 5'd8};
      vecs[10] = '{4'd0,  1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd10, 32'd4, 5'd10};
      vecs[11] = '{4'd3,  1'b0, 1'b0, 1'b0, 32'd3, 32'd1, 32'd0, 32'd0, 5'd11, 32'd8, 5'd11};

      reset = 1'b1; ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
      ea = '0; eb = '0; eimm = '0; epc4 = '0; ern0 = '0; emd_op = OP_NONE;
      repeat (2) next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("reset stall/busy", {62'd0, ebusy, estall}, 64'd0);
      next_cycle();
      emd_op = OP_MFHI;
      @(negedge clk);
      chk("reset HI", 64'(ealu), 64'd0);
      emd_op = OP_MFLO;
      #1;
      chk("reset LO", 64'(ealu), 64'd0);
      emd_op = OP_NONE;
      next_cycle();

      // Directed combinational vectors
      for (int i = 0; i < 12; i++) begin
         ealuc = vecs[i].aluc; ealuimm = vecs[i].aluimm; eshift = vecs[i].shift;
         ejal = vecs[i].jal; ea = vecs[i].a; eb = vecs[i].b; eimm = vecs[i].imm;
         epc4 = vecs[i].pc4; ern0 = vecs[i].rn0;
         @(negedge clk);
         chk($sformatf("vec%0d ealu", i), 64'(ealu), 64'(vecs[i].exp_alu));
         chk($sformatf("vec%0d ern", i), 64'(ern), 64'(vecs[i].exp_rn));
         next_cycle();
      end

      // Random combinational vectors
      for (int i = 0; i < 30; i++) begin
         ealuc = codes[$urandom_range(0, 8)]; ealuimm = 1'($urandom); eshift = 1'($urandom);
         ejal = ($urandom_range(0, 5) == 0); ea = $urandom; eb = $urandom; eimm = $urandom;
         epc4 = $urandom; ern0 = 5'($urandom);
         sa_a = eshift ? {27'd0, eimm[10:6]} : ea;
         exp  = ejal ? epc4 + 32'd4 : alu_ref(ealuc, sa_a, ealuimm ? eimm : eb);
         @(negedge clk);
         chk($sformatf("rand%0d ealu", i), 64'(ealu), 64'(exp));
         chk($sformatf("rand%0d ern", i), 64'(ern), ejal ? 64'd31 : 64'(ern0));
         next_cycle();
      end
      ejal = 1'b0; ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0;

      // Directed MD cases
      run_md("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_md("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_md("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div by 0", OP_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
      run_md("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      run_md("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

      // Random MD ops against the 64-bit reference
      for (int i = 0; i < 12; i++) begin
         rop = 4'($urandom_range(1, 4));
         ra  = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = -32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         md_ref(rop, ra, rb, rh, rl);
         run_md($sformatf("rmd%0d op%0d", i, rop), rop, ra, rb, rh, rl);
      end

      // mthi/mtlo then read back
      emd_op = OP_MTHI; ea = 32'hAA;
      @(negedge clk);
      chk("mthi no stall", 64'(estall), 64'd0);
      next_cycle();
      emd_op = OP_MTLO; ea = 32'h55;
      next_cycle();
      emd_op = OP_MFHI;
      @(negedge clk);
      chk("mfhi after mthi", 64'(ealu), 64'hAA);
      next_cycle();
      emd_op = OP_MFLO;
      @(negedge clk);
      chk("mflo after mtlo", 64'(ealu), 64'h55);
      next_cycle();

      // Reset in RUN cycle 10 of a multu
      emd_op = OP_MULTU; ea = 32'hFFFF_FFFF; eb = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("rst-run start stall", 64'(estall), 64'd1);
      next_cycle();
      repeat (9) next_cycle();
      @(negedge clk);
      chk("rst-run busy at c10", {62'd0, ebusy, estall}, 64'd3);
      reset = 1'b1; emd_op = OP_NONE;
      next_cycle();
      @(negedge clk);
      chk("rst-run stall/busy", {62'd0, ebusy, estall}, 64'd0);
      next_cycle();
      reset = 1'b0; emd_op = OP_MFHI;
      @(negedge clk);
      chk("rst-run HI", 64'(ealu), 64'd0);
      next_cycle();
      emd_op = OP_MFLO;
      @(negedge clk);
      chk("rst-run LO", 64'(ealu), 64'd0);
      next_cycle();
      emd_op = OP_NONE;

      for (int i = 0; i < 1000 && !done16; i++) next_cycle();
      chk("w16 sequence finished", 64'(done16), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // WIDTH=16 instance
   initial begin
      int  stalls;
      bit  done;
      h_reset = 1'b1; h_ealuc = 4'd0; h_ealuimm = 1'b0; h_eshift = 1'b0; h_ejal = 1'b0;
      h_ea = '0; h_eb = '0; h_eimm = '0; h_epc4 = '0; h_ern0 = 5'd2; h_emd_op = OP_NONE;
      repeat (2) next_cycle();
      h_reset = 1'b0;

      h_ealuc = 4'd3; h_eshift = 1'b1; h_eimm = 16'h0100; h_eb = 16'h0123;
      @(negedge clk);
      chk("w16 sll by 4", 64'(h_ealu), 64'h1230);
      next_cycle();
      h_eshift = 1'b0; h_ealuc = 4'd0;

      h_emd_op = OP_MULTU; h_ea = 16'hFFFF; h_eb = 16'hFFFF;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (h_estall) stalls++;
         else done = 1'b1;
         if (!done) next_cycle();
      end
      chk("w16 multu stalls", 64'(stalls), 64'd17);
      next_cycle();
      h_emd_op = OP_MFHI;
      @(negedge clk);
      chk("w16 multu HI", 64'(h_ealu), 64'hFFFE);
      next_cycle();
      h_emd_op = OP_MFLO;
      @(negedge clk);
      chk("w16 multu LO", 64'(h_ealu), 64'h0001);
      next_cycle();
      h_emd_op = OP_NONE;
      done16 = 1'b1;
   end

endmodule
